// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester and ALU-side signal bundle for alu_arbiter
interface alu_arbiter_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_req0_valid;
  logic               i_req1_valid;
  logic               o_req0_ready;
  logic               o_req1_ready;
  logic [NB_DATA-1:0] i_req0_data_a;
  logic [NB_DATA-1:0] i_req0_data_b;
  logic [NB_OP-1:0]   i_req0_op;
  logic [NB_DATA-1:0] i_req1_data_a;
  logic [NB_DATA-1:0] i_req1_data_b;
  logic [NB_OP-1:0]   i_req1_op;
  logic               o_rsp0_valid;
  logic               o_rsp1_valid;
  logic [NB_DATA-1:0] o_rsp0_result;
  logic [NB_DATA-1:0] o_rsp1_result;
  logic               o_alu_valid;
  logic [NB_DATA-1:0] o_alu_data_a;
  logic [NB_DATA-1:0] o_alu_data_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_result;

  // Arbiter side
  modport slave (
    input  i_req0_valid, i_req1_valid,
    input  i_req0_data_a, i_req0_data_b, i_req0_op,
    input  i_req1_data_a, i_req1_data_b, i_req1_op,
    input  i_alu_result,
    output o_req0_ready, o_req1_ready,
    output o_rsp0_valid, o_rsp1_valid,
    output o_rsp0_result, o_rsp1_result,
    output o_alu_valid, o_alu_data_a, o_alu_data_b, o_alu_op
  );

  // Requesters plus ALU side
  modport master (
    output i_req0_valid, i_req1_valid,
    output i_req0_data_a, i_req0_data_b, i_req0_op,
    output i_req1_data_a, i_req1_data_b, i_req1_op,
    output i_alu_result,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp0_valid, o_rsp1_valid,
    input  o_rsp0_result, o_rsp1_result,
    input  o_alu_valid, o_alu_data_a, o_alu_data_b, o_alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one ALU; ALU_ARB_FIXED_PRIO_EN selects fixed priority
module alu_arbiter #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t             state;
  state_t             state_next;
  logic               any_valid;
  logic               grant1_sel;
  logic               accept;
  logic               grantee;
  logic               ready0;
  logic               ready1;
  logic               alu_valid_q;
  logic [NB_DATA-1:0] alu_a_q;
  logic [NB_DATA-1:0] alu_b_q;
  logic [NB_OP-1:0]   alu_op_q;
  logic               rsp0_valid_q;
  logic               rsp1_valid_q;
  logic [NB_DATA-1:0] rsp0_result_q;
  logic [NB_DATA-1:0] rsp1_result_q;

  assign any_valid = bus.i_req0_valid | bus.i_req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 always wins a tie
  assign grant1_sel = bus.i_req1_valid & ~bus.i_req0_valid;
`else
  // last_grant = 1 after reset so requester 0 wins the first tie
  logic last_grant;
  assign grant1_sel = bus.i_req1_valid & (~bus.i_req0_valid | ~last_grant);
`endif

  assign accept = (state == IDLE) & any_valid & ~i_rst;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: one pass IDLE -> ISSUE -> RESP per operation
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_valid) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready outputs: only in IDLE, and never while reset is held
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (state == IDLE && !i_rst && any_valid) begin
      ready1 = grant1_sel;
      ready0 = ~grant1_sel;
    end
  end

  // Datapath: capture on accept, drive ALU in ISSUE, sample result into the grantee's register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      alu_valid_q   <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      grantee       <= 1'b0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant    <= 1'b1;
`endif
    end else begin
      alu_valid_q  <= accept;
      rsp0_valid_q <= (state == ISSUE) & ~grantee;
      rsp1_valid_q <= (state == ISSUE) & grantee;
      if (accept) begin
        grantee  <= grant1_sel;
        alu_a_q  <= grant1_sel ? bus.i_req1_data_a : bus.i_req0_data_a;
        alu_b_q  <= grant1_sel ? bus.i_req1_data_b : bus.i_req0_data_b;
        alu_op_q <= grant1_sel ? bus.i_req1_op     : bus.i_req0_op;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant <= grant1_sel;
`endif
      end
      if (state == ISSUE) begin
        if (grantee) rsp1_result_q <= bus.i_alu_result;
        else         rsp0_result_q <= bus.i_alu_result;
      end
    end
  end

  assign bus.o_req0_ready  = ready0;
  assign bus.o_req1_ready  = ready1;
  assign bus.o_alu_valid   = alu_valid_q;
  assign bus.o_alu_data_a  = alu_a_q;
  assign bus.o_alu_data_b  = alu_b_q;
  assign bus.o_alu_op      = alu_op_q;
  assign bus.o_rsp0_valid  = rsp0_valid_q;
  assign bus.o_rsp1_valid  = rsp1_valid_q;
  assign bus.o_rsp0_result = rsp0_result_q;
  assign bus.o_rsp1_result = rsp1_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with behavioural ALU and arbiter model
module tb_alu_arbiter;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_BAD = 6'h3F;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  alu_arbiter #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD:  alu_ref = a + b;
      OP_SUB:  alu_ref = a - b;
      OP_AND:  alu_ref = a & b;
      OP_OR:   alu_ref = a | b;
      OP_XOR:  alu_ref = a ^ b;
      OP_SRA:  alu_ref = 8'($signed(a) >>> b);
      OP_SRL:  alu_ref = a >> b;
      OP_NOR:  alu_ref = ~(a | b);
      default: alu_ref = 8'h00;
    endcase
  endfunction

  // ALU stand-in: output frozen while i_valid is low
  logic [7:0] alu_hold;
  always_latch begin
    if (bus.o_alu_valid) alu_hold <= alu_ref(bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op);
  end
  assign bus.i_alu_result = alu_hold;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic k, input logic v, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    if (k == 1'b0) begin
      bus.i_req0_valid = v; bus.i_req0_data_a = a; bus.i_req0_data_b = b; bus.i_req0_op = op;
    end else begin
      bus.i_req1_valid = v; bus.i_req1_data_a = a; bus.i_req1_data_b = b; bus.i_req1_op = op;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
    set_req(1'b1, 1'b0, 8'h00, 8'h00, 6'h00);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_ready0"},  32'(bus.o_req0_ready), 32'd0);
    check({tag, "_ready1"},  32'(bus.o_req1_ready), 32'd0);
    check({tag, "_aluv"},    32'(bus.o_alu_valid), 32'd0);
    check({tag, "_alua"},    32'(bus.o_alu_data_a), 32'd0);
    check({tag, "_alub"},    32'(bus.o_alu_data_b), 32'd0);
    check({tag, "_aluop"},   32'(bus.o_alu_op), 32'd0);
    check({tag, "_rspv"},    32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 32'd0);
    check({tag, "_res0"},    32'(bus.o_rsp0_result), 32'd0);
    check({tag, "_res1"},    32'(bus.o_rsp1_result), 32'd0);
  endtask

  typedef struct {
    logic       req;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];

  // One isolated request; entered and left at posedge+1 with the arbiter idle
  task automatic do_single(input vec_t v, input string tag);
    logic [1:0] rsp_exp;
    rsp_exp = v.req ? 2'b10 : 2'b01;
    set_req(v.req, 1'b1, v.a, v.b, v.op);
    @(negedge clk);
    check({tag, "_ready"}, 32'({bus.o_req1_ready, bus.o_req0_ready}), 32'(rsp_exp));
    cycle();
    set_req(v.req, 1'b0, 8'($urandom()), 8'($urandom()), 6'($urandom()));
    @(negedge clk);
    check({tag, "_aluv"}, 32'(bus.o_alu_valid), 32'd1);
    check({tag, "_alu_in"}, 32'({bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op}), 32'({v.a, v.b, v.op}));
    check({tag, "_rsp_early"}, 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 32'd0);
    cycle();
    @(negedge clk);
    check({tag, "_rspv"}, 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 32'(rsp_exp));
    check({tag, "_result"}, 32'(v.req ? bus.o_rsp1_result : bus.o_rsp0_result), 32'(v.exp));
    check({tag, "_aluv_off"}, 32'(bus.o_alu_valid), 32'd0);
    cycle();
    @(negedge clk);
    check({tag, "_rsp_once"}, 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 32'd0);
    check({tag, "_hold"}, 32'(v.req ? bus.o_rsp1_result : bus.o_rsp0_result), 32'(v.exp));
    cycle();
  endtask

  logic [5:0] op_list [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{req: 1'b0, a: 8'h05, b: 8'h03, op: OP_ADD, exp: 8'h08};
    vecs[1] = '{req: 1'b0, a: 8'h0A, b: 8'h03, op: OP_SUB, exp: 8'h07};
    vecs[2] = '{req: 1'b1, a: 8'hF0, b: 8'h3C, op: OP_AND, exp: 8'h30};
    vecs[3] = '{req: 1'b1, a: 8'h55, b: 8'hAA, op: OP_BAD, exp: 8'h00};
    vecs[4] = '{req: 1'b0, a: 8'h0C, b: 8'h30, op: OP_OR,  exp: 8'h3C};
    vecs[5] = '{req: 1'b1, a: 8'hFF, b: 8'h0F, op: OP_XOR, exp: 8'hF0};
    vecs[6] = '{req: 1'b0, a: 8'h80, b: 8'h02, op: OP_SRA, exp: 8'hE0};
    vecs[7] = '{req: 1'b1, a: 8'h80, b: 8'h02, op: OP_SRL, exp: 8'h20};
    vecs[8] = '{req: 1'b0, a: 8'h00, b: 8'h0F, op: OP_NOR, exp: 8'hF0};
    vecs[9] = '{req: 1'b1, a: 8'h03, b: 8'h05, op: OP_SUB, exp: 8'hFE};
    op_list = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR, OP_BAD, 6'h15};

    // Reset with both valids high: readies must stay low
    rst = 1'b1;
    set_req(1'b0, 1'b1, 8'h0A, 8'h03, OP_SUB);
    set_req(1'b1, 1'b1, 8'hF0, 8'h3C, OP_AND);
    #2;
    chk_reset_vals("reset");
    cycle();
    cycle();
    rst = 1'b0;

    // Simultaneous first requests: req0 wins the first tie
    @(negedge clk);
    check("tie_ready", 32'({bus.o_req1_ready, bus.o_req0_ready}), 32'b01);
    cycle();
    set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
    @(negedge clk);
    check("tie_alu_in", 32'({bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op}), 32'({8'h0A, 8'h03, OP_SUB}));
    check("tie_busy_ready", 32'({bus.o_req1_ready, bus.o_req0_ready}), 32'd0);
    cycle();
    @(negedge clk);
    check("tie_rsp0", 32'({bus.o_rsp1_valid, bus.o_rsp0_valid, bus.o_rsp0_result}), 32'({2'b01, 8'h07}));
    check("tie_resp_ready", 32'({bus.o_req1_ready, bus.o_req0_ready}), 32'd0);
    cycle();
    @(negedge clk);
    check("tie_ready1", 32'({bus.o_req1_ready, bus.o_req0_ready}), 32'b10);
    cycle();
    set_req(1'b1, 1'b0, 8'h00, 8'h00, 6'h00);
    cycle();
    @(negedge clk);
    check("tie_rsp1", 32'({bus.o_rsp1_valid, bus.o_rsp0_valid, bus.o_rsp1_result}), 32'({2'b10, 8'h30}));
    check("tie_res0_hold", 32'(bus.o_rsp0_result), 32'h07);
    cycle();

    // Table of isolated operations
    for (int i = 0; i < 10; i++) do_single(vecs[i], $sformatf("vec%0d", i));

    // Both valid held: grant order and 3-cycle spacing
    do_reset();
    set_req(1'b0, 1'b1, 8'h01, 8'h01, OP_ADD);
    set_req(1'b1, 1'b1, 8'h02, 8'h02, OP_ADD);
    for (int c = 0; c < 18; c++) begin
      int         w;
      logic [1:0] onehot;
      w = FIXED ? 0 : (c / 3) % 2;
      onehot = (w == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      check($sformatf("rr_ready_c%0d", c), 32'({bus.o_req1_ready, bus.o_req0_ready}), 32'((c % 3 == 0) ? onehot : 2'b00));
      check($sformatf("rr_rsp_c%0d", c), 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 32'((c % 3 == 2) ? onehot : 2'b00));
      if (c % 3 == 2)
        check($sformatf("rr_res_c%0d", c), 32'((w == 1) ? bus.o_rsp1_result : bus.o_rsp0_result), (w == 1) ? 32'h04 : 32'h02);
      cycle();
    end
    set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
    @(negedge clk);
    check("rr_drop0_ready", 32'({bus.o_req1_ready, bus.o_req0_ready}), 32'b10);
    cycle();
    set_req(1'b1, 1'b0, 8'h00, 8'h00, 6'h00);
    cycle();
    @(negedge clk);
    check("rr_drop0_rsp1", 32'({bus.o_rsp1_valid, bus.o_rsp0_valid, bus.o_rsp1_result}), 32'({2'b10, 8'h04}));
    cycle();

    // Reset during ISSUE: transaction dropped, alu_valid falls at once
    set_req(1'b0, 1'b1, 8'h0C, 8'h30, OP_OR);
    @(negedge clk);
    check("mid_ready0", 32'(bus.o_req0_ready), 32'd1);
    cycle();
    set_req(1'b0, 1'b0, 8'h0C, 8'h30, OP_OR);
    @(negedge clk);
    check("mid_aluv", 32'(bus.o_alu_valid), 32'd1);
    #1;
    rst = 1'b1;
    set_req(1'b0, 1'b1, 8'h0C, 8'h30, OP_OR);
    #1;
    chk_reset_vals("mid_rst");
    cycle();
    set_req(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("mid_no_rsp_c%0d", c), 32'({bus.o_rsp0_valid, bus.o_alu_valid}), 32'd0);
      cycle();
    end
    do_single(vecs[4], "post_rst");

    // Randomized traffic against a transaction-level model
    do_reset();
    begin
      int         phase;
      logic       mlast;
      logic       mwin;
      logic [7:0] cap_a, cap_b;
      logic [5:0] cap_op;
      logic [7:0] res0, res1;
      logic       v0, v1;
      phase = 0; mlast = 1'b1; mwin = 1'b0;
      cap_a = 8'h00; cap_b = 8'h00; cap_op = 6'h00;
      res0 = 8'h00; res1 = 8'h00;
      for (int c = 0; c < 400; c++) begin
        logic       w;
        logic [1:0] exp_rdy;
        logic [1:0] exp_rsp;
        v0 = ($urandom_range(0, 2) != 0);
        v1 = ($urandom_range(0, 2) != 0);
        set_req(1'b0, v0, 8'($urandom()), 8'($urandom()), op_list[$urandom_range(0, 9)]);
        set_req(1'b1, v1, 8'($urandom()), 8'($urandom()), op_list[$urandom_range(0, 9)]);
        w = (v0 && v1) ? (FIXED ? 1'b0 : ~mlast) : v1;
        exp_rdy = (phase == 0 && (v0 || v1)) ? (w ? 2'b10 : 2'b01) : 2'b00;
        exp_rsp = (phase == 2) ? (mwin ? 2'b10 : 2'b01) : 2'b00;
        if (phase == 2) begin
          if (mwin) res1 = alu_ref(cap_a, cap_b, cap_op);
          else      res0 = alu_ref(cap_a, cap_b, cap_op);
        end
        @(negedge clk);
        check($sformatf("rnd_ready_c%0d", c), 32'({bus.o_req1_ready, bus.o_req0_ready}), 32'(exp_rdy));
        check($sformatf("rnd_aluv_c%0d", c), 32'(bus.o_alu_valid), 32'(phase == 1));
        if (phase == 1)
          check($sformatf("rnd_alu_in_c%0d", c), 32'({bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op}), 32'({cap_a, cap_b, cap_op}));
        check($sformatf("rnd_rsp_c%0d", c), 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 32'(exp_rsp));
        check($sformatf("rnd_res_c%0d", c), 32'({bus.o_rsp1_result, bus.o_rsp0_result}), 32'({res1, res0}));
        if (phase == 0 && (v0 || v1)) begin
          mwin   = w;
          mlast  = w;
          cap_a  = w ? bus.i_req1_data_a : bus.i_req0_data_a;
          cap_b  = w ? bus.i_req1_data_b : bus.i_req0_data_b;
          cap_op = w ? bus.i_req1_op     : bus.i_req0_op;
          phase  = 1;
        end else if (phase == 1) begin
          phase = 2;
        end else begin
          phase = 0;
        end
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
